// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the shared memory.
//
// Handshake: a requester raises its req together with a stable address (and,
// for the data port, stable we/wdata) and holds them until it sees its ack.
// The ack is a one-cycle pulse and the matching rdata is valid in that same
// cycle. Dropping req before ack is a protocol violation; the arbiter still
// finishes the latched access and pulses ack.
interface mem_port_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 32,
    parameter int CW = 16
);
    // Fetch requester (read-only)
    logic          w_i_req;
    logic [AW-1:0] w_i_addr;
    logic          w_i_ack;
    logic [DW-1:0] w_i_rdata;

    // Data requester (load/store)
    logic          w_d_req;
    logic          w_d_we;
    logic [AW-1:0] w_d_addr;
    logic [DW-1:0] w_d_wdata;
    logic          w_d_ack;
    logic [DW-1:0] w_d_rdata;

    // Shared memory port (asynchronous read, synchronous write)
    logic [AW-1:0] w_m_addr;
    logic          w_m_we;
    logic [DW-1:0] w_m_din;
    logic [DW-1:0] w_m_dout;

    // Number of arbitration decisions taken with both requesters pending
    logic [CW-1:0] w_conf_cnt;

    // Arbiter side
    modport slave (
        input  w_i_req, w_i_addr,
        input  w_d_req, w_d_we, w_d_addr, w_d_wdata,
        input  w_m_dout,
        output w_i_ack, w_i_rdata,
        output w_d_ack, w_d_rdata,
        output w_m_addr, w_m_we, w_m_din,
        output w_conf_cnt
    );

    // Requesters plus memory side
    modport master (
        output w_i_req, w_i_addr,
        output w_d_req, w_d_we, w_d_addr, w_d_wdata,
        output w_m_dout,
        input  w_i_ack, w_i_rdata,
        input  w_d_ack, w_d_rdata,
        input  w_m_addr, w_m_we, w_m_din,
        input  w_conf_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of one single-port word memory.
// Requester 0 = instruction fetch, requester 1 = data load/store.
// IDLE picks a winner, ACC performs exactly one memory access, RESP pulses
// the ack and may hand the port straight to the other requester.
module mem_port_arbiter #(
    parameter int AW = 11,
    parameter int DW = 32,
    parameter int RR = 1,
    parameter int CW = 16
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    mem_port_arbiter_if.slave    bus,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic          grant_q, grant_d;    // 0 = fetch, 1 = data
    logic          last_q,  last_d;     // requester granted most recently
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic both_req;
    logic pick;

    // Winner of an IDLE decision: a lone requester always wins; on a conflict
    // either alternate away from the last grant or favour the data port.
    always_comb begin
        both_req = bus.w_i_req & bus.w_d_req;
        if (both_req) begin
            pick = (RR != 0) ? ~last_q : 1'b1;
        end else begin
            pick = bus.w_d_req;
        end
    end

    // State register and all datapath registers; reset returns to IDLE with
    // the pointer at the data port so fetch wins the first round-robin tie.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.w_i_req || bus.w_d_req) begin
                    grant_d = pick;
                    state_d = S_ACC;
                    if (both_req && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            S_ACC: begin
                // Memory read data is combinational in this cycle; capture it
                // so the requester sees it alongside its ack.
                state_d = S_RESP;
                last_d  = grant_q;
                if (grant_q) begin
                    d_ack_d = 1'b1;
                    if (!bus.w_d_we) begin
                        d_rdata_d = bus.w_m_dout;
                    end
                end else begin
                    i_ack_d   = 1'b1;
                    i_rdata_d = bus.w_m_dout;
                end
            end

            S_RESP: begin
                // The requester being acked still has req high this cycle, so
                // only the other one is considered for a back-to-back grant.
                if (grant_q ? bus.w_i_req : bus.w_d_req) begin
                    grant_d = ~grant_q;
                    state_d = S_ACC;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory port drive: only active in ACC; write is blocked while reset is
    // asserted so an aborted store never reaches the array.
    always_comb begin
        bus.w_m_addr = '0;
        bus.w_m_we   = 1'b0;
        bus.w_m_din  = '0;
        if (state_q == S_ACC) begin
            bus.w_m_addr = grant_q ? bus.w_d_addr : bus.w_i_addr;
            bus.w_m_we   = grant_q & bus.w_d_we & w_rst_n;
            bus.w_m_din  = bus.w_d_wdata;
        end
    end

    // Registered outputs to the requesters.
    always_comb begin
        bus.w_i_ack    = i_ack_q;
        bus.w_d_ack    = d_ack_q;
        bus.w_i_rdata  = i_rdata_q;
        bus.w_d_rdata  = d_rdata_q;
        bus.w_conf_cnt = cnt_q;
        dbg_state_o    = state_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic w_clk = 1'b0;
  logic w_rst_n = 1'b0;
  int   cyc = 0;

  always #5 w_clk = ~w_clk;
  always @(posedge w_clk) cyc <= cyc + 1;

  // ---------------- DUTs and memory models ----------------
  mem_port_arbiter_if #(.AW(AW), .DW(DW), .CW(16)) bus ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW), .CW(2))  bus2 ();
  logic [1:0] dbg_state;
  logic [1:0] dbg_state2;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RR(1), .CW(16)) u_dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .bus(bus), .dbg_state_o(dbg_state)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .RR(0), .CW(2)) u_dut_fp (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .bus(bus2), .dbg_state_o(dbg_state2)
  );

  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] mem2 [0:(1<<AW)-1];

  assign bus.w_m_dout  = mem[bus.w_m_addr];
  assign bus2.w_m_dout = mem2[bus2.w_m_addr];

  always @(posedge w_clk) begin
    if (bus.w_m_we) mem[bus.w_m_addr] <= bus.w_m_din;
    if (bus2.w_m_we) mem2[bus2.w_m_addr] <= bus2.w_m_din;
  end

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 5) return 32'h2001_0003;
    return 32'hC0DE_0000 | a;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;

  logic [DW-1:0] exp_i_q[$];
  logic [DW-1:0] exp_d_q[$];
  int            exp_i_cyc_q[$];
  int            exp_d_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per ack pulse on the round-robin DUT.
  always @(negedge w_clk) begin
    if (bus.w_m_we) we_cnt++;
    if (bus.w_i_ack) begin
      if (exp_i_q.size() == 0) begin
        check("i_ack_unexpected", 32'd1, 32'd0);
      end else begin
        check("i_rdata", bus.w_i_rdata, exp_i_q.pop_front());
        check("i_ack_cycle", cyc, exp_i_cyc_q.pop_front());
      end
    end
    if (bus.w_d_ack) begin
      if (exp_d_q.size() == 0) begin
        check("d_ack_unexpected", 32'd1, 32'd0);
      end else begin
        check("d_rdata", bus.w_d_rdata, exp_d_q.pop_front());
        check("d_ack_cycle", cyc, exp_d_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp_rd, input int lat);
    bit got = 0;
    @(posedge w_clk); #1;
    bus.w_i_req  = 1'b1;
    bus.w_i_addr = a;
    exp_i_q.push_back(exp_rd);
    exp_i_cyc_q.push_back(cyc + lat);
    for (int n = 0; n < 20; n++) begin
      @(negedge w_clk);
      if (bus.w_i_ack) begin got = 1; break; end
    end
    if (!got) check("i_ack_timeout", 32'd0, 32'd1);
    bus.w_i_req = 1'b0;
  endtask

  task automatic do_data(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp_rd, input int lat);
    bit got = 0;
    @(posedge w_clk); #1;
    bus.w_d_req   = 1'b1;
    bus.w_d_we    = we;
    bus.w_d_addr  = a;
    bus.w_d_wdata = wd;
    exp_d_q.push_back(exp_rd);
    exp_d_cyc_q.push_back(cyc + lat);
    for (int n = 0; n < 20; n++) begin
      @(negedge w_clk);
      if (bus.w_d_ack) begin got = 1; break; end
    end
    if (!got) check("d_ack_timeout", 32'd0, 32'd1);
    bus.w_d_req = 1'b0;
    bus.w_d_we  = 1'b0;
  endtask

  // One conflict round on the fixed-priority DUT: data must win, fetch follows.
  task automatic fp_round(input logic [AW-1:0] ia, input logic [AW-1:0] da, input int exp_cnt);
    int k;
    bit di = 0;
    bit dd = 0;
    @(posedge w_clk); #1;
    k = cyc;
    bus2.w_i_req  = 1'b1;
    bus2.w_i_addr = ia;
    bus2.w_d_req  = 1'b1;
    bus2.w_d_we   = 1'b0;
    bus2.w_d_addr = da;
    for (int n = 0; n < 10; n++) begin
      @(negedge w_clk);
      if (bus2.w_d_ack) begin
        check("fp_d_ack_cycle", cyc, k + 2);
        check("fp_d_rdata", bus2.w_d_rdata, init_word(int'(da)));
        bus2.w_d_req = 1'b0;
        dd = 1;
      end
      if (bus2.w_i_ack) begin
        check("fp_i_ack_cycle", cyc, k + 4);
        check("fp_i_rdata", bus2.w_i_rdata, init_word(int'(ia)));
        bus2.w_i_req = 1'b0;
        di = 1;
      end
      if (di && dd) break;
    end
    if (!(di && dd)) check("fp_ack_timeout", 32'd0, 32'd1);
    check("fp_conf_cnt", 32'(bus2.w_conf_cnt), exp_cnt);
  endtask

  task automatic apply_reset(input int n);
    @(posedge w_clk); #1;
    w_rst_n = 1'b0;
    repeat (n) @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int we0;

    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]  = init_word(i);
      mem2[i] = init_word(i);
    end
    bus.w_i_req = 0;  bus.w_i_addr = '0;
    bus.w_d_req = 0;  bus.w_d_we = 0;  bus.w_d_addr = '0;  bus.w_d_wdata = '0;
    bus2.w_i_req = 0; bus2.w_i_addr = '0;
    bus2.w_d_req = 0; bus2.w_d_we = 0; bus2.w_d_addr = '0; bus2.w_d_wdata = '0;

    // Reset, both requests low, three cycles.
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    check("rst_i_ack", bus.w_i_ack, 0);
    check("rst_d_ack", bus.w_d_ack, 0);
    check("rst_i_rdata", bus.w_i_rdata, 0);
    check("rst_d_rdata", bus.w_d_rdata, 0);
    check("rst_conf_cnt", 32'(bus.w_conf_cnt), 0);
    check("rst_m_we", bus.w_m_we, 0);
    check("rst_state", dbg_state, 0);
    check("rst_fp_conf_cnt", 32'(bus2.w_conf_cnt), 0);
    @(posedge w_clk); #1;
    w_rst_n = 1'b1;

    // Single fetch of mem[5] with cycle-by-cycle observation.
    @(posedge w_clk); #1;
    k = cyc;
    bus.w_i_req  = 1'b1;
    bus.w_i_addr = 11'd5;
    exp_i_q.push_back(32'h2001_0003);
    exp_i_cyc_q.push_back(k + 2);
    @(negedge w_clk);
    @(negedge w_clk);
    check("fetch_acc_cycle", cyc, k + 1);
    check("fetch_m_addr", 32'(bus.w_m_addr), 5);
    check("fetch_m_we", bus.w_m_we, 0);
    check("fetch_no_early_ack", bus.w_i_ack, 0);
    @(negedge w_clk);
    bus.w_i_req = 1'b0;
    @(negedge w_clk);
    check("fetch_ack_one_cycle", bus.w_i_ack, 0);
    check("fetch_rdata_hold", bus.w_i_rdata, 32'h2001_0003);

    // Store then load back; store leaves d_rdata at its reset value.
    we0 = we_cnt;
    do_data(1'b1, 11'd10, 32'hDEAD_BEEF, 32'h0, 2);
    check("store_we_pulses", we_cnt - we0, 1);
    check("store_mem", mem[10], 32'hDEAD_BEEF);
    do_data(1'b0, 11'd10, 32'h0, 32'hDEAD_BEEF, 2);
    do_data(1'b0, 11'd5, 32'h0, 32'h2001_0003, 2);
    check("no_conflict_cnt", 32'(bus.w_conf_cnt), 0);

    // Round-robin conflict right after reset: fetch first, data back-to-back.
    apply_reset(2);
    fork
      do_fetch(11'd7, init_word(7), 2);
      do_data(1'b0, 11'd9, 32'h0, init_word(9), 4);
    join
    check("rr_conf_cnt_1", 32'(bus.w_conf_cnt), 1);

    // Pointer now at data: fetch wins the tie again.
    fork
      do_fetch(11'd11, init_word(11), 2);
      do_data(1'b0, 11'd12, 32'h0, init_word(12), 4);
    join
    check("rr_conf_cnt_2", 32'(bus.w_conf_cnt), 2);

    // Lone fetch moves the pointer to fetch; next tie goes to data.
    do_fetch(11'd13, init_word(13), 2);
    fork
      do_fetch(11'd14, init_word(14), 4);
      do_data(1'b0, 11'd15, 32'h0, init_word(15), 2);
    join
    check("rr_conf_cnt_3", 32'(bus.w_conf_cnt), 3);

    // Fixed data priority; counter of width 2 saturates at 3.
    fp_round(11'd20, 11'd21, 1);
    fp_round(11'd22, 11'd23, 2);
    fp_round(11'd24, 11'd25, 3);
    fp_round(11'd26, 11'd27, 3);

    // Reset asserted during the ACC cycle of a store: no write, no ack.
    @(posedge w_clk); #1;
    bus.w_d_req   = 1'b1;
    bus.w_d_we    = 1'b1;
    bus.w_d_addr  = 11'd3;
    bus.w_d_wdata = 32'hBAD0_BAD0;
    @(negedge w_clk);
    @(negedge w_clk);
    check("abort_in_acc", dbg_state, 1);
    check("abort_we_before", bus.w_m_we, 1);
    w_rst_n = 1'b0;
    bus.w_d_req = 1'b0;
    bus.w_d_we  = 1'b0;
    #1;
    check("abort_we_gated", bus.w_m_we, 0);
    repeat (2) @(negedge w_clk);
    check("abort_mem_kept", mem[3], init_word(3));
    check("abort_no_ack", bus.w_d_ack, 0);
    check("abort_state", dbg_state, 0);
    check("abort_i_rdata", bus.w_i_rdata, 0);
    check("abort_d_rdata", bus.w_d_rdata, 0);
    check("abort_conf_cnt", 32'(bus.w_conf_cnt), 0);
    @(posedge w_clk); #1;
    w_rst_n = 1'b1;
    do_data(1'b0, 11'd3, 32'h0, init_word(3), 2);

    repeat (3) @(negedge w_clk);
    check("i_queue_drained", exp_i_q.size(), 0);
    check("d_queue_drained", exp_d_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port word memory (11-bit word address, 32-bit data, asynchronous read, synchronous write) between two requesters.
- Requester 0 is instruction fetch (read-only). Requester 1 is the data port (load/store).
- Lets the multi-cycle processor use one unified instruction/data memory instead of separate imem/dmem instances.
- Uses a req/ack handshake per requester, round-robin or fixed data-priority arbitration, registered read data, and a saturating conflict counter.

Parameters:
- AW, 11, memory word-address width.
- DW, 32, data width.
- RR, 1, 1 = round-robin on conflict; 0 = data port (requester 1) always wins.
- CW, 16, conflict counter width.

Ports:
- w_clk  input  1  clock; all state updates on rising edge.
- w_rst_n  input  1  synchronous active-low reset.
- w_i_req  input  1  fetch request; held high until w_i_ack.
- w_i_addr  input  AW  fetch word address; stable while w_i_req is high.
- w_i_ack  output  1  one-cycle pulse; w_i_rdata valid in the same cycle.
- w_i_rdata  output  DW  fetched word, registered.
- w_d_req  input  1  data request; held high until w_d_ack.
- w_d_we  input  1  1 = store, 0 = load; stable with w_d_req.
- w_d_addr  input  AW  data word address.
- w_d_wdata  input  DW  store data.
- w_d_ack  output  1  one-cycle pulse on completion of the load or store.
- w_d_rdata  output  DW  load data, registered; unchanged on store.
- w_m_addr  output  AW  shared memory address.
- w_m_we  output  1  shared memory write enable.
- w_m_din  output  DW  shared memory write data.
- w_m_dout  input  DW  shared memory read data (asynchronous, valid within the cycle).
- w_conf_cnt  output  CW  number of arbitration decisions with both requesters pending.

Behaviour:
- Reset (sampled at an edge with w_rst_n low): state=IDLE, grant=0, last-grant pointer=1, both acks 0, both rdata 0, w_conf_cnt 0.
- w_m_we is 0 whenever w_rst_n is low, so no write occurs on a reset edge.
- States:
  - IDLE: drive no access. If any req is high, pick a winner per the arbitration rule, latch the grant, go to ACC.
  - ACC: exactly one cycle.
    - w_m_addr = granted addr.
    - w_m_we = (grant==1 && w_d_we).
    - w_m_din = w_d_wdata.
    - At the edge: memory write commits. On a read, w_m_dout is captured into the granted requester's rdata. Set the granted ack for the next cycle. Update the last-grant pointer to grant. Go to RESP.
  - RESP: granted ack = 1 for this cycle only.
    - The just-acked requester's req is ignored in this cycle.
    - If the other requester's req is high, grant it and go to ACC (back-to-back). Otherwise go to IDLE.
- Arbitration rule (IDLE, both req high):
  - RR=1: grant the requester not equal to the last-grant pointer.
  - RR=0: grant the data port.
  - A single requester always wins.
- Conflict counter: +1 at each IDLE decision with both reqs high. Saturates at all-ones and never wraps.
- Latency:
  - req first sampled high at edge N → ACC in cycle N+1 → ack high in cycle N+2.
  - Throughput: one access per 2 cycles when back-to-back, otherwise 3.
- Outside ACC: w_m_addr=0, w_m_we=0, w_m_din=0.
- rdata holds its value until the next read for that requester; a store does not alter w_d_rdata.
- A requester dropping req before ack is a protocol violation. The block still completes the latched access and pulses ack.
- Reset during ACC or RESP: abort to IDLE with no ack pulse. A store in flight is not written.

Test Plan:
- Reset with both reqs low for 3 cycles → w_i_ack=w_d_ack=0, both rdata=0, w_conf_cnt=0, w_m_we=0.
- mem[5]=0x20010003; w_i_req=1, w_i_addr=5 at edge N → w_m_addr=5 in N+1; w_i_ack=1 and w_i_rdata=0x20010003 in N+2 only.
- Store: w_d_we=1, addr=10, wdata=0xDEADBEEF → w_m_we=1 for exactly one cycle, w_d_ack one cycle later. Then load addr 10 → w_d_rdata=0xDEADBEEF.
- RR=1: both reqs rise together after reset → fetch granted first (pointer=1), data granted directly from RESP with no IDLE. Acks in cycles N+2 and N+4; w_conf_cnt=1.
- RR=0: same stimulus → data granted first, fetch second; w_conf_cnt=1.
- Store to addr 3 issued, w_rst_n driven low during the ACC cycle → mem[3] unchanged, no w_d_ack, state IDLE, rdata=0 after reset.
